// File: rtl/y86_fde_core.sv
// y86_fde_core: fetch, decode and execute stages of a five-stage Y86-64
// pipeline. Holds the F, D and E pipeline registers, the register file and
// the condition codes. The memory and write-back stages live outside and
// feed their forwarding, redirect and write-back data back in.
module y86_fde_core #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        i_clk,
  input  logic        i_reset,
  output logic [63:0] o_imem_addr,
  input  logic [79:0] i_imem_data,
  input  logic        i_imem_error,
  input  logic        i_F_stall,
  input  logic        i_D_stall,
  input  logic        i_D_bubble,
  input  logic        i_E_bubble,
  input  logic [3:0]  i_M_icode,
  input  logic        i_M_cnd,
  input  logic [63:0] i_M_valA,
  input  logic [63:0] i_M_valE,
  input  logic [3:0]  i_M_dstE,
  input  logic [3:0]  i_M_dstM,
  input  logic [63:0] i_m_valM,
  input  logic [3:0]  i_m_stat,
  input  logic [3:0]  i_W_icode,
  input  logic [3:0]  i_W_stat,
  input  logic [3:0]  i_W_dstE,
  input  logic [3:0]  i_W_dstM,
  input  logic [63:0] i_W_valE,
  input  logic [63:0] i_W_valM,
  output logic [3:0]  o_D_icode,
  output logic [3:0]  o_d_srcA,
  output logic [3:0]  o_d_srcB,
  output logic [3:0]  o_E_icode,
  output logic [3:0]  o_E_dstM,
  output logic [3:0]  o_e_stat,
  output logic [3:0]  o_e_icode,
  output logic [3:0]  o_e_dstE,
  output logic [3:0]  o_e_dstM,
  output logic        o_e_cnd,
  output logic [63:0] o_e_valE,
  output logic [63:0] o_e_valA
);

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] S_AOK = 4'h1;
  localparam logic [3:0] S_HLT = 4'h2;
  localparam logic [3:0] S_ADR = 4'h3;
  localparam logic [3:0] S_INS = 4'h4;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RSP   = 4'h4;

  // ---------------------------------------------------------------- fetch
  logic [63:0] r_f_predpc;
  logic [63:0] w_f_pc;
  logic [3:0]  w_f_icode, w_f_ifun, w_f_ra, w_f_rb, w_f_stat;
  logic        w_need_regids, w_need_valc;
  logic [63:0] w_f_valc, w_f_valp, w_f_predpc;

  // PC selection: mispredicted branch in M first, then a returning ret in W
  always_comb begin
    if (i_M_icode == I_JXX && !i_M_cnd) w_f_pc = i_M_valA;
    else if (i_W_icode == I_RET)        w_f_pc = i_W_valM;
    else                                w_f_pc = r_f_predpc;
  end

  assign o_imem_addr = w_f_pc;
  // a bad fetch address turns the slot into a nop carrying ADR status
  assign w_f_icode   = i_imem_error ? I_NOP : i_imem_data[7:4];
  assign w_f_ifun    = i_imem_error ? 4'h0  : i_imem_data[3:0];

  // instruction length fields from icode
  always_comb begin
    w_need_regids = 1'b0;
    w_need_valc   = 1'b0;
    case (w_f_icode)
      I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: w_need_regids = 1'b1;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
        w_need_regids = 1'b1;
        w_need_valc   = 1'b1;
      end
      I_JXX, I_CALL: w_need_valc = 1'b1;
      default: ;
    endcase
  end

  assign w_f_ra   = w_need_regids ? i_imem_data[15:12] : RNONE;
  assign w_f_rb   = w_need_regids ? i_imem_data[11:8]  : RNONE;
  assign w_f_valc = w_need_regids ? i_imem_data[79:16] : i_imem_data[71:8];
  assign w_f_valp = w_f_pc + 64'd1 + {63'd0, w_need_regids}
                           + {60'd0, w_need_valc, 3'b000};
  assign w_f_predpc = (w_f_icode == I_JXX || w_f_icode == I_CALL) ? w_f_valc : w_f_valp;

  // fetch status, address error takes precedence
  always_comb begin
    if (i_imem_error)           w_f_stat = S_ADR;
    else if (w_f_icode > I_POPQ) w_f_stat = S_INS;
    else if (w_f_icode == I_HALT) w_f_stat = S_HLT;
    else                        w_f_stat = S_AOK;
  end

  // F register: predicted PC
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)         r_f_predpc <= RESET_PC;
    else if (!i_F_stall) r_f_predpc <= w_f_predpc;
  end

  // ---------------------------------------------------------------- decode
  logic [3:0]  r_d_stat, r_d_icode, r_d_ifun, r_d_ra, r_d_rb;
  logic [63:0] r_d_valc, r_d_valp;

  // D register: stall holds, bubble inserts a nop, else take fetch outputs
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_d_stat  <= S_AOK;
      r_d_icode <= I_NOP;
      r_d_ifun  <= 4'h0;
      r_d_ra    <= RNONE;
      r_d_rb    <= RNONE;
      r_d_valc  <= 64'h0;
      r_d_valp  <= 64'h0;
    end else if (!i_D_stall) begin
      if (i_D_bubble) begin
        r_d_stat  <= S_AOK;
        r_d_icode <= I_NOP;
        r_d_ifun  <= 4'h0;
        r_d_ra    <= RNONE;
        r_d_rb    <= RNONE;
        r_d_valc  <= 64'h0;
        r_d_valp  <= 64'h0;
      end else begin
        r_d_stat  <= w_f_stat;
        r_d_icode <= w_f_icode;
        r_d_ifun  <= w_f_ifun;
        r_d_ra    <= w_f_ra;
        r_d_rb    <= w_f_rb;
        r_d_valc  <= w_f_valc;
        r_d_valp  <= w_f_valp;
      end
    end
  end

  logic [3:0]  w_d_srca, w_d_srcb, w_d_dste, w_d_dstm;
  logic [63:0] w_rf_a, w_rf_b, w_d_vala, w_d_valb;
  logic [63:0] r_regs [15];

  // register ids used and produced by the instruction in D
  always_comb begin
    w_d_srca = RNONE;
    w_d_srcb = RNONE;
    w_d_dste = RNONE;
    w_d_dstm = RNONE;
    case (r_d_icode)
      I_RRMOVQ: begin w_d_srca = r_d_ra; w_d_dste = r_d_rb; end
      I_IRMOVQ: w_d_dste = r_d_rb;
      I_RMMOVQ: begin w_d_srca = r_d_ra; w_d_srcb = r_d_rb; end
      I_MRMOVQ: begin w_d_srcb = r_d_rb; w_d_dstm = r_d_ra; end
      I_OPQ:    begin w_d_srca = r_d_ra; w_d_srcb = r_d_rb; w_d_dste = r_d_rb; end
      I_CALL:   begin w_d_srcb = RSP; w_d_dste = RSP; end
      I_RET:    begin w_d_srca = RSP; w_d_srcb = RSP; w_d_dste = RSP; end
      I_PUSHQ:  begin w_d_srca = r_d_ra; w_d_srcb = RSP; w_d_dste = RSP; end
      I_POPQ:   begin w_d_srca = RSP; w_d_srcb = RSP; w_d_dste = RSP; w_d_dstm = r_d_ra; end
      default: ;
    endcase
  end

  // combinational register file read; id F matches no entry and reads 0
  always_comb begin
    w_rf_a = 64'h0;
    w_rf_b = 64'h0;
    for (int i = 0; i < 15; i++) begin
      if (w_d_srca == 4'(i)) w_rf_a = r_regs[i];
      if (w_d_srcb == 4'(i)) w_rf_b = r_regs[i];
    end
  end

  // operand A: valP for jumps/calls, else youngest matching producer
  always_comb begin
    if (r_d_icode == I_JXX || r_d_icode == I_CALL) w_d_vala = r_d_valp;
    else if (w_d_srca == RNONE)    w_d_vala = 64'h0;
    else if (w_d_srca == o_e_dstE) w_d_vala = o_e_valE;
    else if (w_d_srca == i_M_dstM) w_d_vala = i_m_valM;
    else if (w_d_srca == i_M_dstE) w_d_vala = i_M_valE;
    else if (w_d_srca == i_W_dstM) w_d_vala = i_W_valM;
    else if (w_d_srca == i_W_dstE) w_d_vala = i_W_valE;
    else                           w_d_vala = w_rf_a;
  end

  // operand B: same forwarding chain without the valP case
  always_comb begin
    if (w_d_srcb == RNONE)         w_d_valb = 64'h0;
    else if (w_d_srcb == o_e_dstE) w_d_valb = o_e_valE;
    else if (w_d_srcb == i_M_dstM) w_d_valb = i_m_valM;
    else if (w_d_srcb == i_M_dstE) w_d_valb = i_M_valE;
    else if (w_d_srcb == i_W_dstM) w_d_valb = i_W_valM;
    else if (w_d_srcb == i_W_dstE) w_d_valb = i_W_valE;
    else                           w_d_valb = w_rf_b;
  end

  // register file write from W; the valM port is applied last so it wins
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < 15; i++) r_regs[i] <= 64'h0;
    end else begin
      for (int i = 0; i < 15; i++) begin
        if (i_W_dstE == 4'(i)) r_regs[i] <= i_W_valE;
        if (i_W_dstM == 4'(i)) r_regs[i] <= i_W_valM;
      end
    end
  end

  assign o_D_icode = r_d_icode;
  assign o_d_srcA  = w_d_srca;
  assign o_d_srcB  = w_d_srcb;

  // ---------------------------------------------------------------- execute
  logic [3:0]  r_e_stat, r_e_icode, r_e_ifun, r_e_dste, r_e_dstm;
  logic [63:0] r_e_valc, r_e_vala, r_e_valb;

  // E register: bubble inserts a nop, else take decode outputs
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset || i_E_bubble) begin
      r_e_stat  <= S_AOK;
      r_e_icode <= I_NOP;
      r_e_ifun  <= 4'h0;
      r_e_valc  <= 64'h0;
      r_e_vala  <= 64'h0;
      r_e_valb  <= 64'h0;
      r_e_dste  <= RNONE;
      r_e_dstm  <= RNONE;
    end else begin
      r_e_stat  <= r_d_stat;
      r_e_icode <= r_d_icode;
      r_e_ifun  <= r_d_ifun;
      r_e_valc  <= r_d_valc;
      r_e_vala  <= w_d_vala;
      r_e_valb  <= w_d_valb;
      r_e_dste  <= w_d_dste;
      r_e_dstm  <= w_d_dstm;
    end
  end

  logic [63:0] w_alua, w_alub, w_alu_res;
  logic [1:0]  w_alufun;
  logic        w_alu_of, w_set_cc, w_cond;
  logic        r_zf, r_sf, r_of;

  // ALU operand selection
  always_comb begin
    w_alua = 64'h0;
    w_alub = 64'h0;
    case (r_e_icode)
      I_RRMOVQ, I_OPQ:             w_alua = r_e_vala;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: w_alua = r_e_valc;
      I_CALL, I_PUSHQ:             w_alua = 64'hFFFF_FFFF_FFFF_FFF8;
      I_RET, I_POPQ:               w_alua = 64'd8;
      default: ;
    endcase
    case (r_e_icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: w_alub = r_e_valb;
      default: ;
    endcase
  end

  // only OPq reaches non-add functions; codes above 3 fall back to add
  assign w_alufun = (r_e_icode == I_OPQ && r_e_ifun < 4'h4) ? r_e_ifun[1:0] : 2'd0;

  // ALU result and signed overflow
  always_comb begin
    w_alu_res = w_alub + w_alua;
    w_alu_of  = (w_alua[63] == w_alub[63]) && (w_alu_res[63] != w_alua[63]);
    case (w_alufun)
      2'd1: begin
        w_alu_res = w_alub - w_alua;
        w_alu_of  = (w_alua[63] != w_alub[63]) && (w_alu_res[63] != w_alub[63]);
      end
      2'd2: begin
        w_alu_res = w_alub & w_alua;
        w_alu_of  = 1'b0;
      end
      2'd3: begin
        w_alu_res = w_alub ^ w_alua;
        w_alu_of  = 1'b0;
      end
      default: ;
    endcase
  end

  // an excepting instruction further down must not see its successors' CC
  assign w_set_cc = (r_e_icode == I_OPQ) && (i_m_stat == S_AOK) && (i_W_stat == S_AOK);

  // condition codes, reset to Z=1 S=0 O=0
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_zf <= 1'b1;
      r_sf <= 1'b0;
      r_of <= 1'b0;
    end else if (w_set_cc) begin
      r_zf <= (w_alu_res == 64'h0);
      r_sf <= w_alu_res[63];
      r_of <= w_alu_of;
    end
  end

  // branch / conditional-move condition from the current CC
  always_comb begin
    case (r_e_ifun)
      4'h0:    w_cond = 1'b1;
      4'h1:    w_cond = (r_sf ^ r_of) | r_zf;
      4'h2:    w_cond = r_sf ^ r_of;
      4'h3:    w_cond = r_zf;
      4'h4:    w_cond = !r_zf;
      4'h5:    w_cond = !(r_sf ^ r_of);
      4'h6:    w_cond = !(r_sf ^ r_of) && !r_zf;
      default: w_cond = 1'b0;
    endcase
  end

  assign o_e_cnd   = (r_e_icode == I_RRMOVQ || r_e_icode == I_JXX) ? w_cond : 1'b0;
  assign o_e_dstE  = (r_e_icode == I_RRMOVQ && !o_e_cnd) ? RNONE : r_e_dste;
  assign o_e_valE  = w_alu_res;
  assign o_e_valA  = r_e_vala;
  assign o_e_stat  = r_e_stat;
  assign o_e_icode = r_e_icode;
  assign o_e_dstM  = r_e_dstm;
  assign o_E_icode = r_e_icode;
  assign o_E_dstM  = r_e_dstm;

endmodule

// File: tb/tb_y86_fde_core.sv
// Bench for y86_fde_core: a byte-array instruction memory, a simple M/W
// register model fed from the e_* outputs, a vector table of single
// instructions, and hand-written multi-cycle sequences.
module tb_y86_fde_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [63:0] imem_addr;
  logic [79:0] imem_data;
  logic        imem_error;
  logic        f_stall, d_stall, d_bubble, e_bubble;
  logic [3:0]  M_icode, M_dstE, M_dstM, m_stat;
  logic        M_cnd;
  logic [63:0] M_valA, M_valE, m_valM;
  logic [3:0]  W_icode, W_stat, W_dstE, W_dstM;
  logic [63:0] W_valE, W_valM;
  logic [3:0]  D_icode, d_srcA, d_srcB, E_icode, E_dstM;
  logic [3:0]  e_stat, e_icode, e_dstE, e_dstM;
  logic        e_cnd;
  logic [63:0] e_valE, e_valA;

  y86_fde_core dut (
    .i_clk(clk), .i_reset(rst),
    .o_imem_addr(imem_addr), .i_imem_data(imem_data), .i_imem_error(imem_error),
    .i_F_stall(f_stall), .i_D_stall(d_stall), .i_D_bubble(d_bubble), .i_E_bubble(e_bubble),
    .i_M_icode(M_icode), .i_M_cnd(M_cnd), .i_M_valA(M_valA), .i_M_valE(M_valE),
    .i_M_dstE(M_dstE), .i_M_dstM(M_dstM), .i_m_valM(m_valM), .i_m_stat(m_stat),
    .i_W_icode(W_icode), .i_W_stat(W_stat), .i_W_dstE(W_dstE), .i_W_dstM(W_dstM),
    .i_W_valE(W_valE), .i_W_valM(W_valM),
    .o_D_icode(D_icode), .o_d_srcA(d_srcA), .o_d_srcB(d_srcB),
    .o_E_icode(E_icode), .o_E_dstM(E_dstM),
    .o_e_stat(e_stat), .o_e_icode(e_icode), .o_e_dstE(e_dstE), .o_e_dstM(e_dstM),
    .o_e_cnd(e_cnd), .o_e_valE(e_valE), .o_e_valA(e_valA)
  );

  // instruction memory
  logic [7:0] mem [256];
  logic [7:0] a8;
  logic       err_at0;
  assign a8 = imem_addr[7:0];
  always_comb begin
    imem_data = '0;
    for (int k = 0; k < 10; k++) imem_data[8*k +: 8] = mem[a8 + 8'(k)];
  end
  assign imem_error = err_at0 && (imem_addr == 64'h0);

  // M/W stage model: e_* -> M -> W, no data memory
  logic [3:0]  pm_stat, pm_icode, pm_dste, pm_dstm, pw_stat, pw_icode, pw_dste, pw_dstm;
  logic        pm_cnd;
  logic [63:0] pm_vale, pm_vala, pw_vale;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pm_stat <= 4'h1; pm_icode <= 4'h1; pm_dste <= 4'hF; pm_dstm <= 4'hF;
      pm_cnd <= 1'b0; pm_vale <= '0; pm_vala <= '0;
      pw_stat <= 4'h1; pw_icode <= 4'h1; pw_dste <= 4'hF; pw_dstm <= 4'hF; pw_vale <= '0;
    end else begin
      pm_stat <= e_stat; pm_icode <= e_icode; pm_dste <= e_dstE; pm_dstm <= e_dstM;
      pm_cnd <= e_cnd; pm_vale <= e_valE; pm_vala <= e_valA;
      pw_stat <= pm_stat; pw_icode <= pm_icode; pw_dste <= pm_dste; pw_dstm <= pm_dstm;
      pw_vale <= pm_vale;
    end
  end

  // manual override of the redirect inputs
  logic        man;
  logic [3:0]  man_m_icode, man_w_icode;
  logic        man_m_cnd;
  logic [63:0] man_m_vala, man_w_valm;
  assign M_icode = man ? man_m_icode : pm_icode;
  assign M_cnd   = man ? man_m_cnd   : pm_cnd;
  assign M_valA  = man ? man_m_vala  : pm_vala;
  assign M_valE  = pm_vale;
  assign M_dstE  = pm_dste;
  assign M_dstM  = pm_dstm;
  assign m_valM  = 64'h0;
  assign m_stat  = pm_stat;
  assign W_icode = man ? man_w_icode : pw_icode;
  assign W_valM  = man ? man_w_valm  : 64'h0;
  assign W_stat  = pw_stat;
  assign W_dstE  = pw_dste;
  assign W_dstM  = pw_dstm;
  assign W_valE  = pw_vale;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h10;
  endtask

  task automatic put(input int addr, input logic [79:0] b, input int len);
    for (int k = 0; k < len; k++) mem[(addr + k) % 256] = b[8*k +: 8];
  endtask

  typedef struct {
    logic [79:0] ins;
    logic        err;
    logic [63:0] pred;
    logic [3:0]  dic, dsa, dsb, est, eic, edste, edstm;
    logic        ecnd;
    logic [63:0] evale, evala;
  } vec_t;

  vec_t vt [16];

  initial begin
    rst = 1'b0; err_at0 = 1'b0;
    f_stall = 1'b0; d_stall = 1'b0; d_bubble = 1'b0; e_bubble = 1'b0;
    man = 1'b0; man_m_icode = 4'h1; man_m_cnd = 1'b0; man_m_vala = '0;
    man_w_icode = 4'h1; man_w_valm = '0;
    clear_mem();

    //         ins                       err  pred    D   sA    sB    st    eic   dE    dM    cnd  valE                   valA
    vt[0]  = '{80'h0000_0000_0000_0005_F030, 0, 64'd10, 3, 4'hF, 4'hF, 1, 3, 4'h0, 4'hF, 0, 64'd5, 64'd0};        // irmovq $5,%rax
    vt[1]  = '{80'h0,                        0, 64'd1,  0, 4'hF, 4'hF, 2, 0, 4'hF, 4'hF, 0, 64'd0, 64'd0};        // halt
    vt[2]  = '{80'hC0,                       0, 64'd1,  4'hC, 4'hF, 4'hF, 4, 4'hC, 4'hF, 4'hF, 0, 64'd0, 64'd0};  // illegal icode C
    vt[3]  = '{80'h0000_0000_0000_0005_F030, 1, 64'd1,  1, 4'hF, 4'hF, 3, 1, 4'hF, 4'hF, 0, 64'd0, 64'd0};        // fetch error
    vt[4]  = '{80'h0000_0000_0000_0000_4070, 0, 64'h40, 7, 4'hF, 4'hF, 1, 7, 4'hF, 4'hF, 1, 64'd0, 64'd9};        // jmp 0x40
    vt[5]  = '{80'h0000_0000_0000_0000_2080, 0, 64'h20, 8, 4'hF, 4'h4, 1, 8, 4'h4, 4'hF, 0, 64'hFFFF_FFFF_FFFF_FFF8, 64'd9}; // call
    vt[6]  = '{80'h3FA0,                     0, 64'd2,  4'hA, 4'h3, 4'h4, 1, 4'hA, 4'h4, 4'hF, 0, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0}; // pushq %rbx
    vt[7]  = '{80'h1FB0,                     0, 64'd2,  4'hB, 4'h4, 4'h4, 1, 4'hB, 4'h4, 4'h1, 0, 64'd8, 64'd0};  // popq %rcx
    vt[8]  = '{80'h0000_0000_0000_0010_7650, 0, 64'd10, 5, 4'hF, 4'h6, 1, 5, 4'hF, 4'h7, 0, 64'h10, 64'd0};       // mrmovq
    vt[9]  = '{80'h2520,                     0, 64'd2,  2, 4'h2, 4'hF, 1, 2, 4'h5, 4'hF, 1, 64'd0, 64'd0};        // rrmovq
    vt[10] = '{80'h2521,                     0, 64'd2,  2, 4'h2, 4'hF, 1, 2, 4'h5, 4'hF, 1, 64'd0, 64'd0};        // cmovle, ZF=1
    vt[11] = '{80'h2522,                     0, 64'd2,  2, 4'h2, 4'hF, 1, 2, 4'hF, 4'hF, 0, 64'd0, 64'd0};        // cmovl, not taken
    vt[12] = '{80'h90,                       0, 64'd1,  9, 4'h4, 4'h4, 1, 9, 4'h4, 4'hF, 0, 64'd8, 64'd0};        // ret
    vt[13] = '{80'h10,                       0, 64'd1,  1, 4'hF, 4'hF, 1, 1, 4'hF, 4'hF, 0, 64'd0, 64'd0};        // nop
    vt[14] = '{80'h0361,                     0, 64'd2,  6, 4'h0, 4'h3, 1, 6, 4'h3, 4'hF, 0, 64'd0, 64'd0};        // subq
    vt[15] = '{80'h0000_0000_0000_0018_4340, 0, 64'd10, 4, 4'h4, 4'h3, 1, 4, 4'hF, 4'hF, 0, 64'h18, 64'd0};       // rmmovq

    // reset state
    do_reset();
    chk("rst_fpc", imem_addr, 64'h0);
    chk("rst_Dic", {60'd0, D_icode}, 64'h1);
    chk("rst_Eic", {60'd0, E_icode}, 64'h1);
    chk("rst_EdM", {60'd0, E_dstM}, 64'hF);
    chk("rst_est", {60'd0, e_stat}, 64'h1);
    chk("rst_edE", {60'd0, e_dstE}, 64'hF);
    chk("rst_evE", e_valE, 64'h0);
    chk("rst_cnd", {63'd0, e_cnd}, 64'h0);

    // single-instruction vectors
    for (int v = 0; v < 16; v++) begin
      clear_mem();
      put(0, vt[v].ins, 10);
      err_at0 = vt[v].err;
      do_reset();
      chk($sformatf("v%0d_pc0", v), imem_addr, 64'h0);
      step();
      chk($sformatf("v%0d_pred", v), imem_addr, vt[v].pred);
      chk($sformatf("v%0d_Dic", v), {60'd0, D_icode}, {60'd0, vt[v].dic});
      chk($sformatf("v%0d_srcA", v), {60'd0, d_srcA}, {60'd0, vt[v].dsa});
      chk($sformatf("v%0d_srcB", v), {60'd0, d_srcB}, {60'd0, vt[v].dsb});
      step();
      chk($sformatf("v%0d_est", v), {60'd0, e_stat}, {60'd0, vt[v].est});
      chk($sformatf("v%0d_eic", v), {60'd0, e_icode}, {60'd0, vt[v].eic});
      chk($sformatf("v%0d_edE", v), {60'd0, e_dstE}, {60'd0, vt[v].edste});
      chk($sformatf("v%0d_edM", v), {60'd0, e_dstM}, {60'd0, vt[v].edstm});
      chk($sformatf("v%0d_cnd", v), {63'd0, e_cnd}, {63'd0, vt[v].ecnd});
      chk($sformatf("v%0d_valE", v), e_valE, vt[v].evale);
      chk($sformatf("v%0d_valA", v), e_valA, vt[v].evala);
      err_at0 = 1'b0;
    end

    // forwarding: irmovq 3,rax; irmovq 4,rbx; addq; cmove; cmovg
    clear_mem();
    put(0,  80'h0000_0000_0000_0003_F030, 10);
    put(10, 80'h0000_0000_0000_0004_F330, 10);
    put(20, 80'h0360, 2);
    put(22, 80'h0123, 2);
    put(24, 80'h0126, 2);
    do_reset();
    step(); step(); step(); step();
    chk("add_eic", {60'd0, e_icode}, 64'h6);
    chk("add_valE", e_valE, 64'd7);
    chk("add_dstE", {60'd0, e_dstE}, 64'h3);
    step();
    chk("cmove_eic", {60'd0, e_icode}, 64'h2);
    chk("cmove_cnd", {63'd0, e_cnd}, 64'h0);
    chk("cmove_dstE", {60'd0, e_dstE}, 64'hF);
    step();
    chk("cmovg_cnd", {63'd0, e_cnd}, 64'h1);
    chk("cmovg_dstE", {60'd0, e_dstE}, 64'h1);
    chk("cmovg_valE", e_valE, 64'd3);

    // subq to zero, je taken, cmovne not taken
    clear_mem();
    put(0,    80'h0000_0000_0000_0009_F230, 10);
    put(10,   80'h2261, 2);
    put(12,   80'h0000_0000_0000_0000_3073, 9);
    put(8'h30, 80'h2624, 2);
    do_reset();
    step(); step(); step();
    chk("sub_valE", e_valE, 64'd0);
    chk("je_D", {60'd0, D_icode}, 64'h7);
    chk("je_fpc", imem_addr, 64'h30);
    step();
    chk("je_eic", {60'd0, e_icode}, 64'h7);
    chk("je_cnd", {63'd0, e_cnd}, 64'h1);
    step();
    chk("cmovne_eic", {60'd0, e_icode}, 64'h2);
    chk("cmovne_cnd", {63'd0, e_cnd}, 64'h0);
    chk("cmovne_dstE", {60'd0, e_dstE}, 64'hF);

    // PC selection priorities
    do_reset();
    man = 1'b1;
    man_m_icode = 4'h7; man_m_cnd = 1'b0; man_m_vala = 64'h40;
    man_w_icode = 4'h1; man_w_valm = 64'h80;
    #1 chk("pcsel_mispred", imem_addr, 64'h40);
    man_m_icode = 4'h1; man_w_icode = 4'h9;
    #1 chk("pcsel_ret", imem_addr, 64'h80);
    man_m_icode = 4'h7;
    #1 chk("pcsel_both", imem_addr, 64'h40);
    man_m_cnd = 1'b1;
    #1 chk("pcsel_taken_ret", imem_addr, 64'h80);
    man = 1'b0;
    #1 chk("pcsel_pred", imem_addr, 64'h0);

    // D stall with E bubble for one cycle (same program as above)
    do_reset();
    step(); step();
    f_stall = 1'b1; d_stall = 1'b1; e_bubble = 1'b1;
    d_bubble = 1'b1;
    step();
    f_stall = 1'b0; d_stall = 1'b0; e_bubble = 1'b0; d_bubble = 1'b0;
    chk("stall_Dic", {60'd0, D_icode}, 64'h6);
    chk("stall_srcA", {60'd0, d_srcA}, 64'h2);
    chk("stall_fpc", imem_addr, 64'd12);
    chk("bub_eic", {60'd0, e_icode}, 64'h1);
    chk("bub_edE", {60'd0, e_dstE}, 64'hF);
    step();
    chk("resume_eic", {60'd0, e_icode}, 64'h6);
    chk("resume_valE", e_valE, 64'd0);

    // asynchronous reset in the middle of a cycle
    clear_mem();
    put(0,  80'h0000_0000_0000_0003_F030, 10);
    put(10, 80'h0000_0000_0000_0004_F330, 10);
    put(20, 80'h0360, 2);
    do_reset();
    step(); step(); step(); step();
    #2 rst = 1'b1;
    #1;
    chk("mid_eic", {60'd0, e_icode}, 64'h1);
    chk("mid_est", {60'd0, e_stat}, 64'h1);
    chk("mid_edE", {60'd0, e_dstE}, 64'hF);
    chk("mid_evE", e_valE, 64'h0);
    chk("mid_Dic", {60'd0, D_icode}, 64'h1);
    chk("mid_fpc", imem_addr, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("post_Dic", {60'd0, D_icode}, 64'h3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
